mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Iterative multiply/divide unit for the EX stage of the pipelined MIPS core.
- Consumes the forwarded register operands (post-forwarding mux3 outputs) and owns the HI/LO register pair for MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO.
- Radix-2, one bit per cycle.
- Drives `busy` to the hazard unit, which stalls MFHI/MFLO and new MDU ops while `busy` is high.

Parameters:
- WIDTH, 32, operand and HI/LO width; the iteration counter is clog2(WIDTH) bits.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- clear  in  1  synchronous flush; aborts the in-flight op
- start  in  1  launch request, sampled only in IDLE
- op  in  2  00=MULTU, 01=MULT, 10=DIVU, 11=DIV
- a  in  WIDTH  rs operand (dividend / multiplicand)
- b  in  WIDTH  rt operand (divisor / multiplier)
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wd  in  WIDTH  MTHI/MTLO data
- busy  out  1  high while the state is not IDLE (combinational from state)
- done  out  1  one-cycle pulse; HI/LO hold new results in that cycle
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, hi=0, lo=0, done=0, counter=0, internal operand regs=0. A mid-operation reset abandons the op.
- States and transitions:
  - IDLE: a cycle with start=1 latches |a|, |b|, the op, the operand signs and the original a; go to CALC with counter=0.
  - CALC: one iteration per edge. After the WIDTH-th iteration (counter==WIDTH-1), go to FIX.
  - FIX: sign correction; hi/lo written; done=1 registered; go to IDLE.
- Latency:
  - start sampled at edge N; busy high from after edge N until edge N+WIDTH+1.
  - hi/lo update and done rise after edge N+WIDTH+1; done falls one edge later.
  - WIDTH=32: 33 busy cycles.
- Magnitudes:
  - Signed ops (MULT, DIV) use two's-complement absolute values.
  - Unsigned ops use operands unchanged.
- Multiply:
  - Shift-add on a 2*WIDTH accumulator.
  - MULT negates the 64-bit product when sign(a)^sign(b).
  - {hi,lo} = product.
- Divide:
  - Restoring shift-subtract.
  - lo = quotient, hi = remainder.
  - DIV: quotient negated if sign(a)^sign(b); remainder takes the sign of a.
- Division by zero (b==0, both DIVU and DIV):
  - Full latency still applies.
  - lo = all ones, hi = original a; no sign fix.
- DIV overflow: a=0x80000000, b=0xFFFFFFFF gives lo=0x80000000, hi=0.
- start while busy: ignored; no queuing.
- start and hi_we/lo_we in the same IDLE cycle: start wins, the write is dropped.
- hi_we/lo_we in IDLE without start: hi/lo <= wd on that edge. Both set: both written.
- hi_we/lo_we while busy: ignored.
- clear:
  - Synchronous; overrides start and the FSM. State goes to IDLE, done=0, and no hi/lo update.
  - clear in FIX suppresses the write.
  - clear in IDLE with hi_we: the write is dropped.
- hi/lo hold their value through the op until FIX; MFHI during busy is the stall unit's job.

Optional Feature:
- Macro MDU_EARLY_EXIT_EN.
- Defined:
  - In CALC for MULT/MULTU, when the remaining unshifted multiplier bits are all zero, go directly to FIX on that edge.
  - Results are identical; latency shrinks. b=0 takes 2 busy cycles: CALC once, then FIX.
  - Division is unaffected.
- Undefined: fixed WIDTH+1 busy cycles for all ops.

Test Plan:
- Reset, then start MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy for 33 cycles; then hi=0xFFFFFFFE, lo=0x00000001, done pulses once.
- MULT a=-7 (0xFFFFFFF9) b=6 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6. DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100 b=0 -> lo=0xFFFFFFFF, hi=100. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Mid-op events on DIVU 100/7:
  - start pulsed again at cycle 10 -> ignored; result lo=14, hi=2.
  - clear at cycle 20 -> busy drops next edge, hi/lo unchanged, no done.
- MTHI/MTLO:
  - hi_we wd=0x1234 in IDLE -> hi=0x1234.
  - hi_we together with start -> write dropped.
  - lo_we while busy -> ignored.
  - reset=0 mid-CALC -> hi=lo=0 and busy=0 immediately.
- With MDU_EARLY_EXIT_EN: MULTU a=5 b=3 -> busy 3 cycles, lo=15. Without the macro: 33 cycles, same result.

Source files
------------

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative radix-2 multiply/divide unit owning HI/LO
// Optional macro MDU_EARLY_EXIT_EN: multiplies end once no multiplier bits remain.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  logic                 sa_q, sa_d;
  logic                 sb_q, sb_d;
  logic [WIDTH-1:0]     aorig_q, aorig_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       rem_sh;
  logic                 rem_ge;
  logic [WIDTH-1:0]     rem_sub;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quot, rem;
  logic                 last_iter;

  // op[0] marks the signed variants, op[1] marks divide.
  always_comb begin
    abs_a   = (op[0] && a[WIDTH-1]) ? (~a + 1'b1) : a;
    abs_b   = (op[0] && b[WIDTH-1]) ? (~b + 1'b1) : b;
    rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_ge  = (rem_sh >= {1'b0, mcand_q[WIDTH-1:0]});
    rem_sub = rem_sh[WIDTH-1:0] - mcand_q[WIDTH-1:0];
    prod    = (sa_q ^ sb_q) ? (~acc_q + 1'b1) : acc_q;
    quot    = acc_q[WIDTH-1:0];
    rem     = acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    aorig_d   = aorig_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    last_iter = (cnt_q == LAST);
`ifdef MDU_EARLY_EXIT_EN
    if (!op_q[1] && ((mplier_q >> 1) == '0)) last_iter = 1'b1;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_CALC;
          cnt_d    = '0;
          op_d     = op;
          sa_d     = op[0] & a[WIDTH-1];
          sb_d     = op[0] & b[WIDTH-1];
          aorig_d  = a;
          mcand_d  = '0;
          mplier_d = '0;
          if (op[1]) begin
            acc_d                  = {{WIDTH{1'b0}}, abs_a};
            mcand_d[WIDTH-1:0]     = abs_b;
          end else begin
            acc_d                  = '0;
            mcand_d[WIDTH-1:0]     = abs_a;
            mplier_d               = abs_b;
          end
        end else begin
          if (hi_we) hi_d = wd;
          if (lo_we) lo_d = wd;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (op_q[1]) begin
          // Restoring divide: acc holds {remainder, dividend/quotient}.
          if (rem_ge) acc_d = {rem_sub, acc_q[WIDTH-2:0], 1'b1};
          else        acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end
        if (last_iter) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
        if (!op_q[1]) begin
          {hi_d, lo_d} = prod;
        end else if (mcand_q[WIDTH-1:0] == '0) begin
          lo_d = '1;
          hi_d = aorig_q;
        end else begin
          lo_d = (sa_q ^ sb_q) ? (~quot + 1'b1) : quot;
          hi_d = sa_q ? (~rem + 1'b1) : rem;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (clear) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      aorig_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      aorig_q  <= aorig_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - self-checking bench for mdu_iter
module tb_mdu_iter;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset, clear, start, hi_we, lo_we;
  logic [1:0]    op;
  logic [W-1:0]  a, b, wd;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .clear(clear), .start(start), .op(op),
    .a(a), .b(b), .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] rhi, output logic [31:0] rlo);
    longint p;
    case (o)
      2'd0: {rhi, rlo} = {32'b0, x} * {32'b0, y};
      2'd1: begin
        p = longint'($signed(x)) * longint'($signed(y));
        {rhi, rlo} = p;
      end
      default: begin
        if (y == 0) begin
          rlo = 32'hFFFFFFFF;
          rhi = x;
        end else if (o == 2'd3 && x == 32'h80000000 && y == 32'hFFFFFFFF) begin
          rlo = 32'h80000000;
          rhi = 32'h0;
        end else if (o == 2'd3) begin
          rlo = $signed(x) / $signed(y);
          rhi = $signed(x) % $signed(y);
        end else begin
          rlo = x / y;
          rhi = x % y;
        end
      end
    endcase
  endfunction

  function automatic int exp_busy(input logic [1:0] o, input logic [31:0] y);
    int n;
    n = W;
`ifdef MDU_EARLY_EXIT_EN
    if (!o[1]) begin
      logic [31:0] m;
      m = (o[0] && y[31]) ? (~y + 32'd1) : y;
      n = 1;
      for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
    end
`else
    if (o[1] && y[0]) n = W;
`endif
    return n + 1;
  endfunction

  task automatic wait_idle(output int cyc, output int dn);
    cyc = 0;
    dn  = 0;
    while (busy && cyc < 100) begin
      cyc++;
      if (done) dn++;
      @(posedge clk); #1;
    end
  endtask

  task automatic run_and_check(input string name, input logic [1:0] o,
                               input logic [31:0] x, input logic [31:0] y,
                               input logic [31:0] ehi, input logic [31:0] elo);
    int cyc, dn;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(cyc, dn);
    check({name, ".busy_cycles"}, 64'(cyc), 64'(exp_busy(o, y)));
    check({name, ".done_early"}, 64'(dn), 64'd0);
    check({name, ".done"}, 64'(done), 64'd1);
    check({name, ".hi"}, 64'(hi), 64'(ehi));
    check({name, ".lo"}, 64'(lo), 64'(elo));
    @(posedge clk); #1;
    check({name, ".done_fall"}, 64'(done), 64'd0);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic mt_write(input logic wh, input logic wl, input logic clr, input logic [31:0] d);
    @(negedge clk);
    hi_we = wh; lo_we = wl; clear = clr; wd = d;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0; clear = 1'b0;
  endtask

  initial begin
    int cyc, dn;
    logic [31:0] rh, rl;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    reset = 1'b0; clear = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'd0; a = '0; b = '0; wd = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.hi", 64'(hi), 64'd0);
    check("reset.lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    vecs.push_back('{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
    vecs.push_back('{2'd1, 32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFD6});
    vecs.push_back('{2'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{2'd2, 32'd100,      32'h00000000, 32'd100,      32'hFFFFFFFF});
    vecs.push_back('{2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000});
    vecs.push_back('{2'd3, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF});
    vecs.push_back('{2'd2, 32'd100,      32'd7,        32'd2,        32'd14});
    vecs.push_back('{2'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD});
    vecs.push_back('{2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});
    vecs.push_back('{2'd0, 32'd5,        32'd3,        32'd0,        32'd15});
    vecs.push_back('{2'd1, 32'h00000000, 32'hFFFFFFFF, 32'd0,        32'd0});
    vecs.push_back('{2'd0, 32'd1,        32'd0,        32'd0,        32'd0});
    vecs.push_back('{2'd2, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF});
    vecs.push_back('{2'd3, 32'h80000000, 32'd1,        32'd0,        32'h80000000});

    for (int i = 0; i < vecs.size(); i++)
      run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = rnd_operand();
      rb = rnd_operand();
      model(ro, ra, rb, rh, rl);
      run_and_check($sformatf("rnd%0d_op%0d_%h_%h", i, ro, ra, rb), ro, ra, rb, rh, rl);
    end

    // Second start mid-op must be ignored.
    @(negedge clk);
    op = 2'd2; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    op = 2'd0; a = 32'd1; b = 32'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(cyc, dn);
    check("restart.busy_cycles", 64'(10 + cyc), 64'd33);
    check("restart.done", 64'(done), 64'd1);
    check("restart.lo", 64'(lo), 64'd14);
    check("restart.hi", 64'(hi), 64'd2);
    @(posedge clk); #1;

    mt_write(1'b1, 1'b0, 1'b0, 32'h1234);
    check("mthi.hi", 64'(hi), 64'h1234);
    check("mthi.lo", 64'(lo), 64'd14);
    mt_write(1'b0, 1'b1, 1'b0, 32'h5678);
    check("mtlo.lo", 64'(lo), 64'h5678);
    check("mtlo.hi", 64'(hi), 64'h1234);
    mt_write(1'b1, 1'b1, 1'b0, 32'hCAFE);
    check("mtboth.hi", 64'(hi), 64'hCAFE);
    check("mtboth.lo", 64'(lo), 64'hCAFE);
    mt_write(1'b1, 1'b0, 1'b1, 32'hDEAD);
    check("clear_mthi.hi", 64'(hi), 64'hCAFE);

    // Clear twenty cycles into a divide.
    @(negedge clk);
    op = 2'd2; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clear.busy", 64'(busy), 64'd0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dn++;
      @(posedge clk); #1;
    end
    check("clear.no_done", 64'(dn), 64'd0);
    check("clear.hi", 64'(hi), 64'hCAFE);
    check("clear.lo", 64'(lo), 64'hCAFE);

    // Clear landing on the final correction cycle.
    @(negedge clk);
    op = 2'd2; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    check("clrfix.busy_before", 64'(busy), 64'd1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clrfix.busy", 64'(busy), 64'd0);
    check("clrfix.done", 64'(done), 64'd0);
    check("clrfix.hi", 64'(hi), 64'hCAFE);
    check("clrfix.lo", 64'(lo), 64'hCAFE);

    // start beats hi_we; lo_we ignored while busy.
    @(negedge clk);
    op = 2'd0; a = 32'd2; b = 32'd3; start = 1'b1; hi_we = 1'b1; wd = 32'h1111;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    check("start_hiwe.hi", 64'(hi), 64'hCAFE);
    check("start_hiwe.busy", 64'(busy), 64'd1);
    @(negedge clk);
    lo_we = 1'b1; wd = 32'h2222;
    @(posedge clk); #1;
    lo_we = 1'b0;
    check("busy_lowe.lo", 64'(lo), 64'hCAFE);
    wait_idle(cyc, dn);
    check("start_hiwe.done", 64'(done), 64'd1);
    check("start_hiwe.res_hi", 64'(hi), 64'd0);
    check("start_hiwe.res_lo", 64'(lo), 64'd6);
    @(posedge clk); #1;

    // Asynchronous reset mid-calculation.
    @(negedge clk);
    op = 2'd2; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_rst.busy", 64'(busy), 64'd0);
    check("async_rst.hi", 64'(hi), 64'd0);
    check("async_rst.lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("after_rst.busy", 64'(busy), 64'd0);
    check("after_rst.done", 64'(done), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
